// File: rtl/input_conditioner.sv
// Debounces a pushbutton and a slide-switch bus: two-flop synchronizers, a
// four-state button FSM with press strobe, and an atomic whole-vector switch filter.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                btn_o,
  output logic                btn_pulse_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                sw_changed_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S0, P1, S1, P0} state_e;

  logic                btn_meta_q, btn_s_q;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_s_q;

  state_e              state_q;
  logic [CNT_W-1:0]    btn_cnt_q;
  logic                btn_q, btn_pulse_q;

  logic [SW_WIDTH-1:0] sw_cand_q, sw_q;
  logic [CNT_W-1:0]    sw_cnt_q;
  logic                sw_changed_q;

  // Stage 0/1: plain two-flop synchronizers, nothing between the flops
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      btn_meta_q <= btn_i;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= sw_i;
      sw_s_q     <= sw_meta_q;
    end
  end

  // Button FSM; btn_q moves only on pending->stable transitions
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= S0;
      btn_cnt_q   <= '0;
      btn_q       <= 1'b0;
      btn_pulse_q <= 1'b0;
    end else begin
      btn_pulse_q <= 1'b0;
      case (state_q)
        S0: if (btn_s_q) begin
          state_q   <= P1;
          btn_cnt_q <= '0;
        end
        P1: if (!btn_s_q) begin
          state_q <= S0;
        end else if (btn_cnt_q == CNT_LAST) begin
          state_q     <= S1;
          btn_q       <= 1'b1;
          btn_pulse_q <= 1'b1;
        end else begin
          btn_cnt_q <= btn_cnt_q + CNT_W'(1);
        end
        S1: if (!btn_s_q) begin
          state_q   <= P0;
          btn_cnt_q <= '0;
        end
        P0: if (btn_s_q) begin
          state_q <= S1;
        end else if (btn_cnt_q == CNT_LAST) begin
          state_q <= S0;
          btn_q   <= 1'b0;
        end else begin
          btn_cnt_q <= btn_cnt_q + CNT_W'(1);
        end
        default: state_q <= S0;
      endcase
    end
  end

  // Switch filter: any bit change restarts the count for the whole vector
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sw_cand_q    <= '0;
      sw_cnt_q     <= '0;
      sw_q         <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_changed_q <= 1'b0;
      if (sw_s_q != sw_cand_q) begin
        sw_cand_q <= sw_s_q;
        sw_cnt_q  <= '0;
      end else if (sw_cand_q != sw_q) begin
        if (sw_cnt_q == CNT_LAST) begin
          sw_q         <= sw_cand_q;
          sw_changed_q <= 1'b1;
        end else begin
          sw_cnt_q <= sw_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign btn_o        = btn_q;
  assign btn_pulse_o  = btn_pulse_q;
  assign sw_o         = sw_q;
  assign sw_changed_o = sw_changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4: press, bounce,
// release, switch glitch/change/restart and reset mid-count.
module tb_input_conditioner;

  logic        clk;
  logic        arst;
  logic        btn;
  logic [15:0] sw;
  logic        btn_o, btn_pulse_o, sw_changed_o;
  logic [15:0] sw_o;

  int n_checks = 0;
  int n_fails  = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(16)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .btn_i        (btn),
    .sw_i         (sw),
    .btn_o        (btn_o),
    .btn_pulse_o  (btn_pulse_o),
    .sw_o         (sw_o),
    .sw_changed_o (sw_changed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_btn(input string tag, input logic lvl, input logic pls);
    check({tag, "_btn_o"}, {31'b0, btn_o}, {31'b0, lvl});
    check({tag, "_pulse"}, {31'b0, btn_pulse_o}, {31'b0, pls});
  endtask

  task automatic check_sw(input string tag, input logic [15:0] val, input logic chg);
    check({tag, "_sw_o"}, {16'b0, sw_o}, {16'b0, val});
    check({tag, "_sw_chg"}, {31'b0, sw_changed_o}, {31'b0, chg});
  endtask

  initial begin
    arst = 1'b1;
    btn  = 1'b0;
    sw   = 16'h0000;
    #2;
    check_btn("reset", 1'b0, 1'b0);
    check_sw("reset", 16'h0000, 1'b0);
    tick();
    tick();
    arst = 1'b0;
    tick();
    check_btn("idle", 1'b0, 1'b0);

    // Clean press: level and strobe after edge 7, strobe gone after edge 8
    btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_btn("press_wait", 1'b0, 1'b0);
    end
    tick();
    check_btn("press_e7", 1'b1, 1'b1);
    tick();
    check_btn("press_e8", 1'b1, 1'b0);

    // Release: same latency, never a strobe
    btn = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_btn("release_wait", 1'b1, 1'b0);
    end
    tick();
    check_btn("release_e7", 1'b0, 1'b0);
    tick();
    check_btn("release_e8", 1'b0, 1'b0);

    // Bounce: 3 high, 2 low, then held; final rise sampled on edge 6 of this step
    btn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_btn("bounce_hi", 1'b0, 1'b0);
    end
    btn = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      check_btn("bounce_lo", 1'b0, 1'b0);
    end
    btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_btn("bounce_wait", 1'b0, 1'b0);
    end
    tick();
    check_btn("bounce_e7", 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_btn("bounce_after", 1'b1, 1'b0);
    end
    btn = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    check_btn("bounce_released", 1'b0, 1'b0);

    // Switch glitch: 0x00A5 for 3 cycles then back
    sw = 16'h00A5;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_sw("glitch_a5", 16'h0000, 1'b0);
    end
    sw = 16'h0000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_sw("glitch_back", 16'h0000, 1'b0);
    end

    // Clean switch change to 0xFFFF
    sw = 16'hFFFF;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_sw("swchg_wait", 16'h0000, 1'b0);
    end
    tick();
    check_sw("swchg_e7", 16'hFFFF, 1'b1);
    tick();
    check_sw("swchg_e8", 16'hFFFF, 1'b0);

    // Mid-count change: heading to 0x0000, switched to 0x1234 after 4 edges
    sw = 16'h0000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_sw("restart_pre", 16'hFFFF, 1'b0);
    end
    sw = 16'h1234;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_sw("restart_wait", 16'hFFFF, 1'b0);
    end
    tick();
    check_sw("restart_e7", 16'h1234, 1'b1);
    tick();
    check_sw("restart_e8", 16'h1234, 1'b0);

    // Reset at count 2 of a press (edge 5), switches held at 0x1234
    btn = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    check_btn("prerst", 1'b0, 1'b0);
    arst = 1'b1;
    #1;
    check_btn("inrst", 1'b0, 1'b0);
    check_sw("inrst", 16'h0000, 1'b0);
    tick();
    check_btn("inrst_edge", 1'b0, 1'b0);
    arst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_btn("postrst_wait", 1'b0, 1'b0);
      check_sw("postrst_wait", 16'h0000, 1'b0);
    end
    tick();
    check_btn("postrst_e7", 1'b1, 1'b1);
    check_sw("postrst_e7", 16'h1234, 1'b1);
    tick();
    check_btn("postrst_e8", 1'b1, 1'b0);
    check_sw("postrst_e8", 16'h1234, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the stable-sample count required before an output changes (legal range 2..2^24).
REQ-002 SHALL have parameter SW_WIDTH, default 16, meaning the width of the switch bus.
REQ-003 SHALL have port clk_i, input, 1 bit, the single system clock (rising edge).
REQ-004 SHALL have port arst_i, input, 1 bit, the asynchronous active-high reset.
REQ-005 SHALL have port btn_i, input, 1 bit, the raw asynchronous pushbutton.
REQ-006 SHALL have port sw_i, input, SW_WIDTH bits, the raw asynchronous slide switches.
REQ-007 SHALL have port btn_o, output, 1 bit, the debounced button level (feeds the SoC irq_btn_i).
REQ-008 SHALL have port btn_pulse_o, output, 1 bit, a one-cycle strobe on each debounced press.
REQ-009 SHALL have port sw_o, output, SW_WIDTH bits, the debounced switch vector (feeds the SoC gpio_bi field).
REQ-010 SHALL have port sw_changed_o, output, 1 bit, a one-cycle strobe when sw_o updates.

Function
REQ-011 SHALL pass btn_i and every sw_i bit through a two-flop synchronizer (btn_s, sw_s); there SHALL be no other logic between the two flops.
REQ-012 SHALL implement the button FSM with states S0 (stable low), P1 (pending high), S1 (stable high) and P0 (pending low), plus one counter btn_cnt of width clog2(DEBOUNCE_CYCLES).
REQ-013 SHALL make these FSM transitions:
- S0 -> P1 when btn_s=1, with btn_cnt<=0.
- S1 -> P0 when btn_s=0, with btn_cnt<=0.
REQ-014 SHALL, in P1:
- go to S0 if btn_s=0 (bounce rejected, btn_o unchanged);
- otherwise go to S1 if btn_cnt==DEBOUNCE_CYCLES-1;
- otherwise increment btn_cnt.
REQ-015 SHALL, in P0:
- go to S1 if btn_s=1;
- otherwise go to S0 if btn_cnt==DEBOUNCE_CYCLES-1;
- otherwise increment btn_cnt.
REQ-016 SHALL register btn_o as 1 in S1 and P0, and 0 in S0 and P1.
REQ-017 SHALL assert btn_pulse_o for exactly the one cycle after the P1->S1 transition, and SHALL NOT assert it on release.
REQ-018 SHALL, for a held btn_i, set btn_o high after the (DEBOUNCE_CYCLES+3)th rising edge counted from the first edge that samples btn_i high; release latency SHALL be the same.
REQ-019 SHALL track switches with a candidate register sw_cand (SW_WIDTH bits) and a counter sw_cnt, updated as follows:
- If sw_s != sw_cand: sw_cand<=sw_s and sw_cnt<=0.
- Else, if sw_cand != sw_o: when sw_cnt==DEBOUNCE_CYCLES-1, sw_o<=sw_cand and sw_changed_o<=1 for one cycle; otherwise sw_cnt++.
- Else: sw_cnt holds.
REQ-020 SHALL give a clean switch change the same DEBOUNCE_CYCLES+3 edge latency as REQ-018.
REQ-021 SHALL apply any bit change during counting by restarting the count for the whole vector; simultaneous multi-bit changes SHALL update sw_o atomically in one cycle.
REQ-022 SHALL leave sw_o unchanged and sw_changed_o low if the switches return to the current sw_o value before the count completes.
REQ-023 SHALL never let either counter wrap: the counter value is used only while below DEBOUNCE_CYCLES-1 and is cleared on every state entry.
REQ-024 SHALL keep button and switch paths independent; simultaneous events on both SHALL each complete with their own timing.

Reset
REQ-025 SHALL, while arst_i=1, asynchronously force:
- both synchronizer stages to 0;
- FSM to S0;
- btn_cnt=0, sw_cnt=0, sw_cand=0;
- btn_o=0, btn_pulse_o=0, sw_o=0, sw_changed_o=0.
REQ-026 SHALL resume after reset deassertion on the next rising edge; an in-progress debounce SHALL be discarded, and inputs held high through reset SHALL re-qualify with the full REQ-018 latency.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover a clean press: btn_i 0->1 held -> btn_o=1 and btn_pulse_o=1 after edge 7, btn_pulse_o=0 after edge 8.
REQ-028 SHALL cover bounce: btn_i high for 3 cycles, low for 2, then held high -> no pulse during the bounce, exactly one btn_pulse_o, btn_o=1 7 edges after the final rise.
REQ-029 SHALL cover a switch glitch: sw_i 0x0000->0x00A5 for 3 cycles, then back to 0x0000 -> sw_o stays 0x0000, sw_changed_o never asserts.
REQ-030 SHALL cover a switch change: sw_i 0x0000->0xFFFF held -> sw_o=0xFFFF with a one-cycle sw_changed_o 7 edges later; a change to 0x1234 mid-count restarts the count, and sw_o=0x1234 7 edges after that change.
REQ-031 SHALL cover reset mid-count: arst_i pulsed at count 2 of a press -> all outputs 0 immediately; with btn_i still high, btn_o=1 7 edges after reset release.
